// File: rtl/cam_pkg.sv
// cam_pkg: shared state type, pixel format constants and address sizing for the camera capture path
package cam_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, WAIT_FRAME, CAPTURE} state_t;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int PIX_W = R_W + G_W + B_W;
  function automatic int addr_width(input int w, input int h, input int sub);
    int n;
    n = (w >> sub) * (h >> sub);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cam_capture_ctrl_if.sv
// cam_capture_ctrl_if: frame-buffer pixel write port with valid/ready handshake
interface cam_capture_ctrl_if import cam_pkg::*; #(parameter int ADDR_W = 19);
  logic wr_valid;
  logic wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [PIX_W-1:0] wr_data;
  modport master(output wr_valid, wr_addr, wr_data, input wr_ready);
  modport slave(input wr_valid, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/cam_pix_pack.sv
// cam_pix_pack: byte phase, byte pairing into RGB565 pixels and decimation keep decision
module cam_pix_pack import cam_pkg::*; #(parameter int SUB = 0) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [7:0]       dat,
  input  logic [1:0]       col_lsb,
  input  logic [1:0]       row_lsb,
  output logic             phase,
  output logic             pix_ok,
  output logic             keep,
  output logic [PIX_W-1:0] pix
);
  localparam logic [1:0] M = 2'((1 << SUB) - 1);
  logic [7:0] hi;
  assign pix_ok = en & phase;
  assign pix = {hi, dat};
  assign keep = ((col_lsb | row_lsb) & M) == 2'b00;
  always_ff @(posedge clk) begin
    if (rst || clr) phase <= 1'b0;
    else if (en) phase <= ~phase;
    if (en && !phase) hi <= dat;
  end
endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: camera frame capture sequencer with geometry checks and a single-slot pixel write port
module cam_capture_ctrl import cam_pkg::*; #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int SUB    = 0,
  parameter int ADDR_W = addr_width(IMG_W, IMG_H, SUB)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_dat,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  cam_capture_ctrl_if.master  fb,
  output logic                busy,
  output logic                frame_done,
  output logic                err_line,
  output logic                err_frame,
  output logic                overrun
);
  localparam int CW = $clog2(IMG_W + 2);
  localparam int RW = $clog2(IMG_H + 2);
  localparam logic [CW-1:0] W_END = CW'(IMG_W);
  localparam logic [RW-1:0] H_END = RW'(IMG_H);
  state_t state;
  logic cont, vs_d, hr_d;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] addr;
  logic phase, pix_ok, keep;
  logic [PIX_W-1:0] pix;
  logic vs_rise, vs_fall, hr_fall, cap, clr, take;
  assign vs_rise = cam_vsync & ~vs_d;
  assign vs_fall = ~cam_vsync & vs_d;
  assign hr_fall = ~cam_href & hr_d;
  assign cap = state == CAPTURE;
  assign clr = (state == WAIT_FRAME && vs_fall) || (cap && hr_fall);
  assign take = pix_ok && keep && col < W_END && row < H_END;
  cam_pix_pack #(.SUB(SUB)) u_pack (
    .clk,
    .rst(reset),
    .en(cap & cam_href),
    .clr,
    .dat(cam_dat),
    .col_lsb(col[1:0]),
    .row_lsb(row[1:0]),
    .phase,
    .pix_ok,
    .keep,
    .pix
  );
  always_ff @(posedge clk) begin
    vs_d <= cam_vsync;
    hr_d <= cam_href;
    frame_done <= 1'b0;
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      cont <= 1'b0;
      err_line <= 1'b0;
      err_frame <= 1'b0;
      overrun <= 1'b0;
      fb.wr_valid <= 1'b0;
      fb.wr_addr <= '0;
      fb.wr_data <= '0;
      col <= '0;
      row <= '0;
      addr <= '0;
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      fb.wr_valid <= 1'b0;
    end else begin
      if (fb.wr_valid && fb.wr_ready) fb.wr_valid <= 1'b0;
      if (take) begin
        addr <= addr + 1'b1;
        if (fb.wr_valid && !fb.wr_ready) overrun <= 1'b1;
        else begin
          fb.wr_valid <= 1'b1;
          fb.wr_addr <= addr;
          fb.wr_data <= pix;
        end
      end
      if (pix_ok && col <= W_END) col <= col + 1'b1;
      if (cap && hr_fall) begin
        if (col != W_END || phase) err_line <= 1'b1;
        if (row <= H_END) row <= row + 1'b1;
        col <= '0;
      end
      case (state)
        IDLE: if (start) begin
          state <= SYNC;
          busy <= 1'b1;
          cont <= continuous;
          err_line <= 1'b0;
          err_frame <= 1'b0;
          overrun <= 1'b0;
        end
        SYNC: if (vs_rise) state <= WAIT_FRAME;
        WAIT_FRAME: if (vs_fall) begin
          state <= CAPTURE;
          col <= '0;
          row <= '0;
          addr <= '0;
        end
        default: if (vs_rise) begin
          if (row != H_END) err_frame <= 1'b1;
          frame_done <= 1'b1;
          state <= cont ? WAIT_FRAME : IDLE;
          busy <= cont;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// tb_cam_capture_ctrl: directed frames checked against a per-cycle capture model and literal expectations
module tb_cam_capture_ctrl;
  import cam_pkg::*;
  localparam int W0 = 4;
  localparam int H0 = 3;
  localparam int S0 = 0;
  localparam int K0 = 1 << S0;
  localparam int AW0 = addr_width(W0, H0, S0);
  localparam int AW1 = addr_width(4, 2, 1);
  logic clk = 0;
  logic reset = 1;
  logic cam_vsync = 0;
  logic cam_href = 0;
  logic [7:0] cam_dat = 0;
  logic start = 0;
  logic continuous = 0;
  logic abort = 0;
  logic busy, frame_done, err_line, err_frame, overrun;
  logic busy1, frame_done1, err_line1, err_frame1, overrun1;
  int vectors = 0;
  int fails = 0;
  int fd_cnt = 0;
  logic [7:0] bytec = 0;
  logic [AW0+15:0] log0[$];
  logic [AW1+15:0] log1[$];
  cam_capture_ctrl_if #(.ADDR_W(AW0)) if0();
  cam_capture_ctrl_if #(.ADDR_W(AW1)) if1();
  assign if1.wr_ready = 1'b1;
  cam_capture_ctrl #(.IMG_W(W0), .IMG_H(H0), .SUB(S0), .ADDR_W(AW0)) dut (
    .clk, .reset, .cam_vsync, .cam_href, .cam_dat, .start, .continuous, .abort,
    .fb(if0), .busy, .frame_done, .err_line, .err_frame, .overrun
  );
  cam_capture_ctrl #(.IMG_W(4), .IMG_H(2), .SUB(1), .ADDR_W(AW1)) dut1 (
    .clk, .reset, .cam_vsync, .cam_href, .cam_dat, .start, .continuous, .abort,
    .fb(if1), .busy(busy1), .frame_done(frame_done1), .err_line(err_line1),
    .err_frame(err_frame1), .overrun(overrun1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  int m_mode = 0, nbytes = 0, nline = 0, nout = 0, m_addr = 0, px = 0;
  bit m_cont, m_valid, m_fd, m_el, m_ef, m_ov, pv, ph, vr, vf, hf, acc;
  logic [15:0] m_data = 0;
  logic [7:0] prev_b = 0;
  always @(posedge clk) begin
    vr = cam_vsync && !pv;
    vf = !cam_vsync && pv;
    hf = !cam_href && ph;
    acc = m_valid && if0.wr_ready;
    pv = cam_vsync;
    ph = cam_href;
    m_fd = 0;
    if (reset) begin
      m_mode = 0; m_valid = 0; m_el = 0; m_ef = 0; m_ov = 0; m_cont = 0;
    end else if (abort) begin
      m_mode = 0; m_valid = 0;
    end else begin
      if (acc) m_valid = 0;
      if (m_mode == 0 && start) begin
        m_mode = 1; m_cont = continuous; m_el = 0; m_ef = 0; m_ov = 0;
      end else if (m_mode == 1 && vr) m_mode = 2;
      else if (m_mode == 2 && vf) begin
        m_mode = 3; nbytes = 0; nline = 0; nout = 0;
      end else if (m_mode == 3) begin
        if (cam_href) begin
          nbytes++;
          px = nbytes / 2 - 1;
          if (nbytes % 2 == 0 && px < W0 && nline < H0 && px % K0 == 0 && nline % K0 == 0) begin
            if (m_valid) m_ov = 1;
            else begin
              m_valid = 1; m_addr = nout; m_data = {prev_b, cam_dat};
            end
            nout++;
          end
          prev_b = cam_dat;
        end
        if (vr) begin
          if (nline != H0) m_ef = 1;
          m_fd = 1;
          m_mode = m_cont ? 2 : 0;
        end
        if (hf) begin
          if (nbytes != 2 * W0) m_el = 1;
          nline++;
          nbytes = 0;
        end
      end
    end
  end
  always @(negedge clk) if (!reset) begin
    chk("busy", busy, m_mode != 0);
    chk("frame_done", frame_done, m_fd);
    chk("err_line", err_line, m_el);
    chk("err_frame", err_frame, m_ef);
    chk("overrun", overrun, m_ov);
    chk("wr_valid", if0.wr_valid, m_valid);
    if (m_valid) begin
      chk("wr_addr", if0.wr_addr, m_addr);
      chk("wr_data", if0.wr_data, m_data);
    end
  end
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (if0.wr_valid && if0.wr_ready) log0.push_back({if0.wr_addr, if0.wr_data});
    if (if1.wr_valid && if1.wr_ready) log1.push_back({if1.wr_addr, if1.wr_data});
  end
  function automatic logic [AW0+15:0] ent0(input int i);
    return i < log0.size() ? log0[i] : '1;
  endfunction
  function automatic logic [AW1+15:0] ent1(input int i);
    return i < log1.size() ? log1[i] : '1;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input bit cont);
    continuous = cont;
    start = 1;
    cyc();
    start = 0;
    continuous = 0;
    chk("busy_after_start", busy, 1);
  endtask
  task automatic line(input int nb, input bit stall, input bit ab);
    for (int i = 0; i < nb; i++) begin
      cam_href = 1;
      cam_dat = bytec;
      bytec++;
      if0.wr_ready = !(stall && i >= 2 && i <= 5);
      abort = ab && i == 4;
      cyc();
      if (ab && i == 4) begin
        abort = 0;
        cam_href = 0;
        if0.wr_ready = 1;
        chk("abort_wr_valid", if0.wr_valid, 0);
        chk("abort_busy", busy, 0);
        return;
      end
    end
    cam_href = 0;
    if0.wr_ready = 1;
    repeat (3) cyc();
  endtask
  task automatic frame(input int sl, input int stl, input int abl);
    cam_vsync = 1;
    repeat (4) cyc();
    cam_vsync = 0;
    bytec = 0;
    repeat (2) cyc();
    for (int l = 0; l < 3; l++) begin
      line(l == sl ? 7 : 8, l == stl, l == abl);
      if (l == abl) return;
    end
  endtask
  task automatic vs_end();
    cam_vsync = 1;
    repeat (4) cyc();
    cam_vsync = 0;
    repeat (2) cyc();
  endtask
  int fd0;
  initial begin
    if0.wr_ready = 1;
    repeat (3) cyc();
    chk("rst_wr_valid", if0.wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_addr", if0.wr_addr, 0);
    chk("rst_wr_data", if0.wr_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_flags", {err_line, err_frame, overrun}, 0);
    reset = 0;
    cyc();
    fd0 = fd_cnt;
    go(0);
    frame(-1, -1, -1);
    vs_end();
    chk("t1_count", log0.size(), 12);
    chk("t1_first", ent0(0), 20'h00001);
    chk("t1_last", ent0(11), 20'hB1617);
    chk("t1_frame_done", fd_cnt - fd0, 1);
    chk("t1_idle", busy, 0);
    chk("t1_sub_count", log1.size(), 2);
    chk("t1_sub_w0", ent1(0), 17'h00001);
    chk("t1_sub_w1", ent1(1), 17'h10405);
    chk("t1_sub_err_frame", err_frame1, 1);
    log0.delete();
    go(0);
    line(8, 0, 0);
    chk("t2_no_early", log0.size(), 0);
    frame(-1, -1, -1);
    vs_end();
    chk("t2_count", log0.size(), 12);
    chk("t2_first", ent0(0), 20'h00001);
    log0.delete();
    fd0 = fd_cnt;
    go(0);
    frame(1, -1, -1);
    vs_end();
    chk("t3_err_line", err_line, 1);
    chk("t3_err_frame", err_frame, 0);
    chk("t3_frame_done", fd_cnt - fd0, 1);
    chk("t3_count", log0.size(), 11);
    chk("t3_w6", ent0(6), 20'h60C0D);
    chk("t3_last", ent0(10), 20'hA1516);
    log0.delete();
    go(0);
    frame(-1, 1, -1);
    vs_end();
    chk("t4_overrun", overrun, 1);
    chk("t4_err_line", err_line, 0);
    chk("t4_count", log0.size(), 10);
    chk("t4_held", ent0(4), 20'h40809);
    chk("t4_after", ent0(5), 20'h70E0F);
    chk("t4_last", ent0(9), 20'hB1617);
    log0.delete();
    fd0 = fd_cnt;
    go(1);
    frame(-1, -1, -1);
    frame(-1, -1, -1);
    frame(-1, 1, 1);
    repeat (6) cyc();
    chk("t5_frame_done", fd_cnt - fd0, 2);
    chk("t5_count", log0.size(), 28);
    chk("t5_f2_first", ent0(12), 20'h00001);
    chk("t5_f3_first", ent0(24), 20'h00001);
    chk("t5_idle", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
